// File: rtl/dircc_node_mem_arbiter.sv
// dircc_node_mem_arbiter: round-robin arbiter sharing one single-port RAM among node memory ports
module dircc_node_mem_arbiter #(
  parameter int NUM_NODES  = 4,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic [NUM_NODES*ADDR_W-1:0]   node_mem_address,
  input  logic [NUM_NODES-1:0]          node_mem_read,
  input  logic [NUM_NODES-1:0]          node_mem_write,
  input  logic [NUM_NODES*DATA_W-1:0]   node_mem_writedata,
  output logic [NUM_NODES-1:0]          node_mem_waitrequest,
  output logic [NUM_NODES*DATA_W-1:0]   node_mem_readdata,
  output logic [NUM_NODES-1:0]          node_mem_readdatavalid,
  output logic                          err_range,
  output logic                          err_collision
);
  localparam int IW = $clog2(NUM_NODES);
  logic [IW-1:0] last_q, gnt_idx, cand;
  logic gnt_any, g_rd, g_wr, oor, we, re, oor_q, err_range_q, err_coll_q;
  logic [NUM_NODES-1:0] req, gnt_oh, rdv_q;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, ram_q, rd_word;
  logic [NUM_NODES-1:0][DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
  assign req = node_mem_read | node_mem_write;
  // scan from farthest to nearest so the node right after last_q wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = NUM_NODES; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_NODES);
      if (req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_any = gnt_any & ~reset_reset;
  end
  assign gnt_oh = gnt_any ? NUM_NODES'(1) << gnt_idx : '0;
  assign node_mem_waitrequest = req & ~gnt_oh;
  always_comb begin
    addr = '0;
    wdata = '0;
    g_rd = 1'b0;
    g_wr = 1'b0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (gnt_idx == IW'(i)) begin
        addr = node_mem_address[i*ADDR_W +: ADDR_W];
        wdata = node_mem_writedata[i*DATA_W +: DATA_W];
        g_rd = node_mem_read[i];
        g_wr = node_mem_write[i];
      end
    end
  end
  assign oor = (addr >> MEM_ADDR_W) != '0;
  assign we = gnt_any & g_wr & ~oor;
  assign re = gnt_any & g_rd & ~g_wr;
  always_ff @(posedge clk_clk) begin
    if (we) mem[addr[MEM_ADDR_W-1:0]] <= wdata;
    else ram_q <= mem[addr[MEM_ADDR_W-1:0]];
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      last_q <= IW'(NUM_NODES - 1);
      rdv_q <= '0;
      oor_q <= 1'b0;
      hold_q <= '0;
      err_range_q <= 1'b0;
      err_coll_q <= 1'b0;
    end else begin
      if (gnt_any) last_q <= gnt_idx;
      rdv_q <= re ? gnt_oh : '0;
      oor_q <= oor;
      for (int i = 0; i < NUM_NODES; i++)
        if (rdv_q[i]) hold_q[i] <= rd_word;
      err_range_q <= err_range_q | (gnt_any & oor);
      err_coll_q <= err_coll_q | (gnt_any & g_rd & g_wr);
    end
  end
  assign rd_word = oor_q ? '0 : ram_q;
  // a read granted just before reset must not surface while reset is held
  assign node_mem_readdatavalid = rdv_q & {NUM_NODES{~reset_reset}};
  for (genvar i = 0; i < NUM_NODES; i++) begin : g_rd_out
    assign node_mem_readdata[i*DATA_W +: DATA_W] = node_mem_readdatavalid[i] ? rd_word : hold_q[i];
  end
  assign err_range = err_range_q;
  assign err_collision = err_coll_q;
endmodule

// File: tb/tb_dircc_node_mem_arbiter.sv
// tb_dircc_node_mem_arbiter: scoreboard bench with a round-robin/RAM reference model
module tb_dircc_node_mem_arbiter;
  localparam int N = 4, AW = 15, DW = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N*AW-1:0] addr_bus;
  logic [N-1:0] rd_bus, wr_bus, wreq, rdv;
  logic [N*DW-1:0] wd_bus, rdata;
  logic e_range, e_coll;
  logic rq_rd[N], rq_wr[N];
  logic [AW-1:0] rq_a[N];
  logic [DW-1:0] rq_d[N];
  dircc_node_mem_arbiter dut (
    .clk_clk(clk), .reset_reset(rst),
    .node_mem_address(addr_bus), .node_mem_read(rd_bus), .node_mem_write(wr_bus),
    .node_mem_writedata(wd_bus), .node_mem_waitrequest(wreq),
    .node_mem_readdata(rdata), .node_mem_readdatavalid(rdv),
    .err_range(e_range), .err_collision(e_coll));
  always_comb begin
    addr_bus = '0;
    wd_bus = '0;
    rd_bus = '0;
    wr_bus = '0;
    for (int i = 0; i < N; i++) begin
      rd_bus[i] = rq_rd[i];
      wr_bus[i] = rq_wr[i];
      addr_bus[i*AW +: AW] = rq_a[i];
      wd_bus[i*DW +: DW] = rq_d[i];
    end
  end
  typedef struct { int cyc; int node; logic [DW-1:0] data; } exp_t;
  exp_t q[$];
  logic [DW-1:0] mmem [int];
  logic [DW-1:0] last_rd [N];
  int cyc = 0, checks = 0, fails = 0, last = N - 1;
  bit x_rng, x_col;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // reference model: round-robin over the bench's own request set, RAM as an associative array
  always @(negedge clk) begin
    logic [N-1:0] rv;
    int g, ma;
    bit o;
    for (int i = 0; i < N; i++) rv[i] = rq_rd[i] | rq_wr[i];
    if (rst) begin
      chk("wait_in_reset", wreq, rv);
      q.delete();
      last = N - 1;
      x_rng = 0;
      x_col = 0;
    end else begin
      chk("err_range", e_range, x_rng);
      chk("err_collision", e_coll, x_col);
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && rv[(last + k) % N]) g = (last + k) % N;
      chk("waitrequest", wreq, g < 0 ? rv : rv & ~(N'(1) << g));
      if (g >= 0) begin
        ma = int'(rq_a[g]) % 4096;
        o = rq_a[g] >= 4096;
        if (o) x_rng = 1;
        if (rq_rd[g] && rq_wr[g]) x_col = 1;
        if (rq_wr[g]) begin
          if (!o) mmem[ma] = rq_d[g];
        end else q.push_back('{cyc, g, o ? '0 : mmem[ma]});
        last = g;
      end
    end
  end
  // monitor: pops the scoreboard whenever a readdatavalid pulse appears
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rdv_in_reset", rdv, '0);
      for (int i = 0; i < N; i++) last_rd[i] = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rdv[i]) begin
          if (q.size() == 0 || q[0].cyc + 1 != cyc) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rdv node=%0d actual=1 required=0 (cycle %0d)", i, cyc);
          end else begin
            e = q.pop_front();
            chk("rdv_node", i, e.node);
            chk("readdata", rdata[i*DW +: DW], e.data);
            last_rd[i] = e.data;
          end
        end else chk("readdata_hold", rdata[i*DW +: DW], last_rd[i]);
      end
      while (q.size() > 0 && q[0].cyc + 1 < cyc) begin
        checks++;
        fails++;
        $display("FAIL missing_rdv node=%0d actual=0 required=1 (cycle %0d)", q[0].node, cyc);
        void'(q.pop_front());
      end
    end
  end
  task automatic issue(int n, bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    @(posedge clk);
    #1;
    rq_rd[n] = rd;
    rq_wr[n] = wr;
    rq_a[n] = a;
    rq_d[n] = d;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (!wreq[n]) break;
      if (t > 20) begin
        checks++;
        fails++;
        $display("FAIL grant_timeout node=%0d actual=waiting required=granted", n);
        break;
      end
    end
  endtask
  task automatic idle(int n);
    @(posedge clk);
    #1;
    rq_rd[n] = 0;
    rq_wr[n] = 0;
  endtask
  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < N; i++) begin
      rq_rd[i] = 0;
      rq_wr[i] = 0;
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic rand_ops(int n, int cnt);
    int r;
    logic [AW-1:0] a;
    for (int j = 0; j < cnt; j++) begin
      r = int'($urandom_range(0, 9));
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a | AW'('h1000);
      issue(n, r != 9 ? r < 5 : 1'b1, r >= 5, a, DW'($urandom));
      if ($urandom_range(0, 2) == 0) idle(n);
    end
    idle(n);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      rq_rd[i] = 0;
      rq_wr[i] = 0;
      rq_a[i] = '0;
      rq_d[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    for (int a = 0; a < 16; a++) issue(0, 0, 1, AW'(a), DW'($urandom));
    issue(0, 0, 1, 5, 16'h1234);
    issue(0, 1, 0, 5, 0);
    idle(0);
    for (int n = 0; n < N; n++) begin
      automatic int m = n;
      fork
        begin
          repeat (4) issue(m, 1, 0, AW'(m + 8), 0);
          idle(m);
        end
      join_none
    end
    wait fork;
    fork
      begin issue(2, 0, 1, 7, 16'hBEEF); idle(2); end
      begin issue(3, 1, 0, 7, 0); idle(3); end
    join
    issue(1, 1, 0, 15'h1000, 0);
    issue(1, 0, 1, 15'h1000, 16'h5555);
    issue(1, 1, 0, 0, 0);
    idle(1);
    issue(0, 1, 1, 3, 16'hA5A5);
    issue(0, 1, 0, 3, 0);
    idle(0);
    do_reset(2);
    issue(1, 1, 0, 4, 0);
    do_reset(2);
    for (int n = 0; n < N; n++) begin
      automatic int m = n;
      fork
        begin issue(m, 1, 0, AW'(m), 0); idle(m); end
      join_none
    end
    wait fork;
    for (int n = 0; n < N; n++) begin
      automatic int m = n;
      fork
        rand_ops(m, 40);
      join_none
    end
    wait fork;
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dircc_node_mem_arbiter.md
DIRCC_NODE_MEM_ARBITER -- requirements
Module: dircc_node_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_NODES, default 4, number of node memory ports (2..16).
- ADDR_W, default 15, node-side word address width.
- DATA_W, default 16, data width.
- MEM_ADDR_W, default 12, shared RAM address width (depth 2^MEM_ADDR_W words, MEM_ADDR_W <= ADDR_W).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk_clk  in  1  clock.
- reset_reset  in  1  synchronous active-high reset.
- node_mem_address  in  NUM_NODES*ADDR_W  per-node address; node i in bits [i*ADDR_W +: ADDR_W].
- node_mem_read  in  NUM_NODES  per-node read request.
- node_mem_write  in  NUM_NODES  per-node write request.
- node_mem_writedata  in  NUM_NODES*DATA_W  per-node write data.
- node_mem_waitrequest  out  NUM_NODES  per-node stall.
- node_mem_readdata  out  NUM_NODES*DATA_W  per-node read data.
- node_mem_readdatavalid  out  NUM_NODES  per-node read-data strobe.
- err_range  out  1  sticky flag: out-of-range access.
- err_collision  out  1  sticky flag: read and write asserted together.

Function
REQ-004 The block SHALL contain one single-port RAM of 2^MEM_ADDR_W x DATA_W words, shared by all nodes.
REQ-005 A node SHALL request when node_mem_read[i] or node_mem_write[i] is 1.
REQ-006 A requesting node SHALL hold address, data and command stable until its waitrequest is 0.
REQ-007 At most one node SHALL be granted per cycle. Arbitration SHALL be round-robin starting from the node after last_grant.
REQ-008 last_grant SHALL update to the granted index only in cycles where a grant occurs.
REQ-009 node_mem_waitrequest[i] SHALL be combinational: 1 if node i requests and is not granted this cycle, otherwise 0.
REQ-010 Granted write: RAM[address[MEM_ADDR_W-1:0]] SHALL be updated at the clock edge that ends the grant cycle.
REQ-011 Granted read: node_mem_readdatavalid[i] SHALL pulse high for exactly one cycle, one cycle after the grant (fixed latency 1). node_mem_readdata[i] SHALL carry the RAM word in that cycle.
REQ-012 node_mem_readdata[i] SHALL hold its last value until node i's next readdatavalid.
REQ-013 Out of range: if address[ADDR_W-1:MEM_ADDR_W] != 0, the access SHALL still be granted and SHALL set err_range.
- Write: dropped; RAM is unchanged.
- Read: returns 0 with the normal readdatavalid pulse.
REQ-014 Read and write asserted together on a granted node: the write SHALL be performed, no readdatavalid SHALL be issued, and err_collision SHALL be set.
REQ-015 Accesses are ordered by grant order. A read granted in a cycle after a write to the same address SHALL return the new data.
REQ-016 A node requesting continuously SHALL wait at most NUM_NODES-1 cycles for a grant.
REQ-017 err_range and err_collision SHALL clear only on reset.

Reset
REQ-018 While reset_reset=1, at each clock edge:
- last_grant <= NUM_NODES-1, so node 0 has first priority after reset.
- All readdatavalid <= 0, all readdata <= 0, both err flags <= 0.
REQ-019 While reset_reset=1, no grant SHALL occur and all node_mem_waitrequest bits SHALL be 1 for every requesting node.
REQ-020 Reset asserted mid-operation: a read granted in the cycle before reset SHALL NOT produce readdatavalid.
REQ-021 RAM contents SHALL NOT be reset.

Verification
REQ-022 After reset, node 0 writes 0x1234 to address 5, then reads address 5 -> readdatavalid[0] one cycle after the read grant; readdata[0]=0x1234.
REQ-023 All 4 nodes request reads continuously -> grants in order 0,1,2,3,0,...; each waitrequest low exactly 1 cycle in every 4.
REQ-024 Node 2 writes 0xBEEF to address 7 and node 3 simultaneously reads address 7 -> node 2 is granted first; node 3 reads 0xBEEF.
REQ-025 Node 1 reads address 0x1000 (MEM_ADDR_W=12) -> readdata[1]=0 with readdatavalid[1]; err_range=1. A write to 0x1000 leaves RAM[0] unchanged.
REQ-026 Node 0 asserts read and write together -> write performed, no readdatavalid[0], err_collision=1. Reset asserted -> both flags 0.
REQ-027 Node 1's read is granted, then reset is asserted on the next cycle -> no readdatavalid[1]. After reset, node 0 wins the first grant.
